// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Synchronizes a raw, bouncy, asynchronous level input and only
//            passes a new level to dout after it has been seen stable for
//            DEBOUNCE_CYCLES consecutive synchronized samples. Transitions
//            that collapse before qualifying are counted as glitches.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SYNC_STAGES     : synchronizer depth on din (>= 2)
//   DEBOUNCE_CYCLES : stable samples required to change dout (>= 1)
//   GLITCH_W        : width of the saturating glitch counter
// Ports
//   clk        in   clock, all logic on the rising edge
//   resetn     in   synchronous, active-low reset
//   din        in   raw asynchronous level input
//   glitch_clr in   synchronous clear of glitch_cnt (wins over a glitch)
//   dout       out  registered debounced level
//   busy       out  high while a new level is being qualified
//   glitch_cnt out  saturating count of rejected transitions
// ============================================================================
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                din,
  input  logic                glitch_clr,
  output logic                dout,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  // Counter is wide enough to hold DEBOUNCE_CYCLES itself.
  localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W:0]   C_CNT_LAST = (C_CNT_W + 1)'(DEBOUNCE_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_CHK_H = 2'd1,
    ST_HIGH  = 2'd2,
    ST_CHK_L = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizer chain; only the last stage is used by the logic below.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Qualification state machine
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [C_CNT_W-1:0]    cnt_q, cnt_d;
  logic [C_CNT_W:0]      cnt_inc;
  logic                  glitch_ev;
  logic                  dout_q, busy_q;
  logic [GLITCH_W-1:0]   glitch_q, glitch_d;

  // One extra bit so the compare against DEBOUNCE_CYCLES cannot overflow.
  assign cnt_inc = {1'b0, cnt_q} + (C_CNT_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    glitch_ev = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = ST_CHK_H;
            cnt_d   = C_CNT_ONE;
          end
        end
      end
      ST_CHK_H: begin
        if (sync_s) begin
          if (cnt_inc == C_CNT_LAST) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[C_CNT_W-1:0];
          end
        end else begin
          // Bounce back: abandon qualification, restart from zero.
          state_d   = ST_LOW;
          cnt_d     = '0;
          glitch_ev = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!sync_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            state_d = ST_CHK_L;
            cnt_d   = C_CNT_ONE;
          end
        end
      end
      ST_CHK_L: begin
        if (!sync_s) begin
          if (cnt_inc == C_CNT_LAST) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[C_CNT_W-1:0];
          end
        end else begin
          state_d   = ST_HIGH;
          cnt_d     = '0;
          glitch_ev = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear has priority over a glitch arriving in the same cycle.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_ev && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // the state machine moves.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= (state_d == ST_HIGH)  || (state_d == ST_CHK_L);
      busy_q   <= (state_d == ST_CHK_H) || (state_d == ST_CHK_L);
      glitch_q <= glitch_d;
    end
  end

  assign dout       = dout_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule
`default_nettype wire

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, which is the number of synchronizer flops on din (legal values >= 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, which is the number of consecutive stable synchronized samples required to change dout (legal values >= 1).
REQ-003 The block SHALL have parameter GLITCH_W, default 8, which is the width of the glitch counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port din, input, 1 bit: raw asynchronous, bouncy level input.
REQ-007 The block SHALL have port glitch_clr, input, 1 bit: synchronous clear of glitch_cnt.
REQ-008 The block SHALL have port dout, output, 1 bit: registered, debounced clean level that feeds the downstream edge-detect stage.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the state is a qualification (CHK_*) state.
REQ-010 The block SHALL have port glitch_cnt, output, GLITCH_W bits: saturating count of rejected transitions.

Function
REQ-011 din SHALL pass through a chain of SYNC_STAGES flops; s, the last stage, SHALL be the only value used by the block logic.
REQ-012 The state machine SHALL have the states LOW, CHK_H, HIGH and CHK_L; a qualification counter cnt SHALL be sized to hold DEBOUNCE_CYCLES.
REQ-013 LOW: when s=1, the next state SHALL be CHK_H with cnt=1, or HIGH directly if DEBOUNCE_CYCLES==1; otherwise the state SHALL stay LOW.
REQ-014 CHK_H: when s=1 and cnt+1==DEBOUNCE_CYCLES, the next state SHALL be HIGH; when s=1 otherwise, cnt SHALL increment; when s=0, the next state SHALL be LOW and a glitch event SHALL be raised.
REQ-015 HIGH and CHK_L SHALL be the mirror of LOW and CHK_H with s inverted, so that s=1 in CHK_L returns the state to HIGH and raises a glitch event.
REQ-016 dout SHALL be a flop equal to 1 exactly when the state is HIGH or CHK_L, so that dout changes on the same edge the state enters HIGH or LOW.
REQ-017 Latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges from the first edge that samples a stable new din level to the change of dout.
REQ-018 dout SHALL never toggle more than once per qualified transition, and a qualified transition SHALL always produce exactly one dout edge.
REQ-019 busy SHALL be 1 exactly when the state is CHK_H or CHK_L.
REQ-020 Each glitch event SHALL increment glitch_cnt by 1, saturating at 2^GLITCH_W-1 with no wrap.
REQ-021 When glitch_clr=1, glitch_cnt SHALL be 0 on the next edge, and the clear SHALL win over a glitch event in the same cycle.
REQ-022 cnt SHALL be reset to 0 on every entry to LOW or HIGH, and a bounce SHALL restart qualification from zero.

Reset
REQ-023 When resetn=0 at an edge, all synchronizer flops SHALL be 0, the state SHALL be LOW, cnt SHALL be 0, dout SHALL be 0, busy SHALL be 0 and glitch_cnt SHALL be 0.
REQ-024 Reset asserted mid-qualification or while the state is HIGH SHALL abort to LOW, with dout=0 on the next edge and no glitch counted.
REQ-025 After resetn returns to 1 with din held high, dout SHALL rise after the full latency defined in REQ-017.
REQ-026 glitch_clr SHALL be ignored while resetn=0.

Verification
REQ-027 With defaults, if din rises after edge 0 and is held, then s=1 from edge 2 and dout SHALL be 1 after edge 6, with busy=1 after edges 3 to 5.
REQ-028 With defaults, din high for 3 cycles then low SHALL leave dout at 0, raise glitch_cnt to 1, and return the state to LOW.
REQ-029 With dout=1, a 1-cycle low pulse on din SHALL leave dout at 1 and raise glitch_cnt by 1; a held low SHALL make dout 0 exactly 6 edges after sampling.
REQ-030 With GLITCH_W=2, 5 glitch events SHALL leave glitch_cnt at 3; glitch_clr coincident with a glitch event SHALL give glitch_cnt=0.
REQ-031 With DEBOUNCE_CYCLES=1, a held din rise SHALL make dout 1 exactly 3 edges after sampling, with busy never asserted.
REQ-032 Asserting resetn=0 for 1 cycle while in CHK_H, with din held at 1, SHALL give dout=0, busy=0 and glitch_cnt unchanged-to-0, followed by a dout rise 6 edges after release.
